fpmin_argmin_sched: RTL and testbench

//  Sequencer for the fpmintree datapath. Streams one query's candidate distances TW at a time into an

---
 rtl/fpmin_argmin_sched_pkg.sv | 34 +++
 rtl/fpmin_argmin_sched_tree.sv | 53 +++++
 rtl/fpmin_argmin_sched.sv | 176 +++++++++++++++++
 tb/tb_fpmin_argmin_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmin_argmin_sched_pkg.sv
// Shared definitions for the argmin sequencer: float field widths, the
// float less-than helper and the accumulator state encoding.
package fpmin_argmin_sched_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_DW    = 1 + FP_EXP_W + FP_MAN_W;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HAVE   = 2'd1,
    ST_RESULT = 2'd2
  } acc_state_e;

  // Sign/magnitude less-than; both zeros compare equal regardless of sign.
  function automatic logic fp_lt(input logic [FP_DW-1:0] a, input logic [FP_DW-1:0] b);
    logic [FP_DW-2:0] mag_a;
    logic [FP_DW-2:0] mag_b;
    logic             lt;
    mag_a = a[FP_DW-2:0];
    mag_b = b[FP_DW-2:0];
    if ((mag_a == '0) && (mag_b == '0)) begin
      lt = 1'b0;
    end else if (a[FP_DW-1] != b[FP_DW-1]) begin
      lt = a[FP_DW-1];
    end else if (a[FP_DW-1]) begin
      lt = (mag_a > mag_b);
    end else begin
      lt = (mag_a < mag_b);
    end
    return lt;
  endfunction

endpackage

// File: rtl/fpmin_argmin_sched_tree.sv
// Pipelined min tree: one registered compare per level, lane index carried
// along with the value. Ties resolve to the lower lane.
module fpmin_argmin_sched_tree
  import fpmin_argmin_sched_pkg::*;
#(
  parameter int DW = 32,
  parameter int TW = 8,
  parameter int IW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [TW*DW-1:0] xd,
  output logic [DW-1:0]    md,
  output logic [IW-1:0]    mi
);

  // Heap layout: node n has children 2n (lower lanes) and 2n+1; leaves at TW..2TW-1.
  logic [DW-1:0] cand_val_s [1:2*TW-1];
  logic [IW-1:0] cand_idx_s [1:2*TW-1];
  logic [DW-1:0] node_val_r [1:TW-1];
  logic [IW-1:0] node_idx_r [1:TW-1];

  for (genvar k = 0; k < TW; k++) begin : g_leaf
    assign cand_val_s[TW+k] = xd[k*DW +: DW];
    assign cand_idx_s[TW+k] = IW'(k);
  end

  for (genvar n = 1; n < TW; n++) begin : g_node
    assign cand_val_s[n] = node_val_r[n];
    assign cand_idx_s[n] = node_idx_r[n];

    // Right child wins only when strictly smaller.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        node_val_r[n] <= '0;
        node_idx_r[n] <= '0;
      end else if (ena) begin
        if (fp_lt(cand_val_s[2*n+1], cand_val_s[2*n])) begin
          node_val_r[n] <= cand_val_s[2*n+1];
          node_idx_r[n] <= cand_idx_s[2*n+1];
        end else begin
          node_val_r[n] <= cand_val_s[2*n];
          node_idx_r[n] <= cand_idx_s[2*n];
        end
      end
    end
  end

  assign md = node_val_r[1];
  assign mi = node_idx_r[1];

endmodule

// File: rtl/fpmin_argmin_sched.sv
// Argmin sequencer: feeds beats into the min tree, tags them with batch/last,
// and folds tree outputs into a per-query global minimum with valid/ready out.
module fpmin_argmin_sched
  import fpmin_argmin_sched_pkg::*;
#(
  parameter int DW = 32,
  parameter int TW = 8,
  parameter int IW = 3,
  parameter int GW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TW*DW-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [GW-1:0]    out_idx,
  output logic [DW-1:0]    out_data,
  output logic             busy,
  output logic             ovf
);

  localparam int BW = GW - IW;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [BW-1:0] batch;
  } tag_t;

  logic          run_r;
  logic          stall_s;
  logic          ena_s;
  logic          beat_s;
  logic [BW-1:0] batch_r;
  logic          ovf_r;
  tag_t          tag_r [IW];
  logic [IW-1:0] tag_vld_s;
  logic [DW-1:0] root_val_s;
  logic [IW-1:0] root_idx_s;
  logic          exit_vld_s;
  logic          exit_last_s;
  acc_state_e    state_r;
  acc_state_e    next_state_s;
  logic          load_s;
  logic [GW-1:0] acc_idx_r;
  logic [DW-1:0] acc_val_r;

  assign stall_s = (state_r == ST_RESULT) & ~out_ready;
  assign ena_s   = ~stall_s;
  assign in_ready = run_r & ~stall_s;
  assign beat_s  = in_valid & in_ready;

  fpmin_argmin_sched_tree #(.DW(DW), .TW(TW), .IW(IW)) u_tree (
    .clk (clk),
    .rst (rst),
    .ena (ena_s),
    .xd  (in_data),
    .md  (root_val_s),
    .mi  (root_idx_s)
  );

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Batch number within the current query; a wrap inside a query is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      batch_r <= '0;
      ovf_r   <= 1'b0;
    end else if (beat_s) begin
      if (in_last) begin
        batch_r <= '0;
      end else begin
        batch_r <= batch_r + BW'(1);
        if (&batch_r) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  // Tag stage 0 captures the beat; bubbles enter with vld=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_r[0] <= '0;
    end else if (ena_s) begin
      tag_r[0] <= '{vld: beat_s, last: in_last, batch: batch_r};
    end
  end

  for (genvar i = 1; i < IW; i++) begin : g_tag
    // Tag shift stays in lockstep with the tree levels.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tag_r[i] <= '0;
      end else if (ena_s) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  for (genvar i = 0; i < IW; i++) begin : g_vld
    assign tag_vld_s[i] = tag_r[i].vld;
  end

  assign exit_vld_s  = tag_r[IW-1].vld;
  assign exit_last_s = tag_r[IW-1].last;

  // Accumulator next state; a handshake in RESULT processes the exit beat as EMPTY would.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (exit_vld_s) begin
          load_s       = 1'b1;
          next_state_s = exit_last_s ? ST_RESULT : ST_HAVE;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      ST_HAVE: begin
        if (exit_vld_s) begin
          load_s       = fp_lt(root_val_s, acc_val_r);
          next_state_s = exit_last_s ? ST_RESULT : ST_HAVE;
        end else begin
          next_state_s = ST_HAVE;
        end
      end
      ST_RESULT: begin
        if (!out_ready) begin
          next_state_s = ST_RESULT;
        end else if (exit_vld_s) begin
          load_s       = 1'b1;
          next_state_s = exit_last_s ? ST_RESULT : ST_HAVE;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      default: begin
        next_state_s = ST_EMPTY;
      end
    endcase
  end

  // Accumulator state and running minimum pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_EMPTY;
      acc_idx_r <= '0;
      acc_val_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        acc_idx_r <= {tag_r[IW-1].batch, root_idx_s};
        acc_val_r <= root_val_s;
      end
    end
  end

  assign out_valid = (state_r == ST_RESULT);
  assign out_idx   = acc_idx_r;
  assign out_data  = acc_val_r;
  assign busy      = (|tag_vld_s) | (state_r != ST_EMPTY);
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_fpmin_argmin_sched.sv
// Self-checking bench for fpmin_argmin_sched (TW=4, IW=2, GW=16): directed
// cases plus randomized queries checked against a real-valued argmin model.
module tb_fpmin_argmin_sched;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int IW = 2;
  localparam int GW = 16;
  localparam int LAT = IW + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [TW*DW-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [GW-1:0]    out_idx;
  logic [DW-1:0]    out_data;
  logic             busy;
  logic             ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic rand_bp = 1'b0;

  logic [TW*DW-1:0] cur_beats [$];
  logic [GW-1:0]    exp_idx_q [$];
  logic [DW-1:0]    exp_data_q [$];
  logic [GW-1:0]    res_idx_q [$];
  logic [DW-1:0]    res_data_q [$];
  int               res_cyc_q [$];

  fpmin_argmin_sched #(.DW(DW), .TW(TW), .IW(IW), .GW(GW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result that is consumed on the coming edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      res_idx_q.push_back(out_idx);
      res_data_q.push_back(out_data);
      res_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [TW*DW-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                              input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'(120 + $urandom_range(0, 14));
    m = 23'($urandom);
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // Model: first strictly smallest candidate in arrival order; index = beat*TW+lane mod 2^GW.
  task automatic model_query();
    real         best_v;
    logic [31:0] best_bits;
    int          best_i;
    logic [TW*DW-1:0] beat;
    logic [31:0] lane;
    best_v = 0.0;
    best_bits = 32'h0;
    best_i = -1;
    for (int b = 0; b < cur_beats.size(); b++) begin
      beat = cur_beats[b];
      for (int l = 0; l < TW; l++) begin
        lane = beat[l*DW +: DW];
        if (best_i < 0 || f2r(lane) < best_v) begin
          best_v = f2r(lane);
          best_bits = lane;
          best_i = b * TW + l;
        end
      end
    end
    exp_idx_q.push_back(GW'(best_i % (1 << GW)));
    exp_data_q.push_back(best_bits);
    cur_beats.delete();
  endtask

  task automatic send_beat(input logic [TW*DW-1:0] d, input logic last);
    logic ok;
    int   n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'(ok), 64'd1);
    cur_beats.push_back(d);
    if (last) model_query();
  endtask

  task automatic wait_results(input string tag, input int n);
    for (int i = 0; i < 300 && res_idx_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 64'(res_idx_q.size()), 64'(n));
  endtask

  task automatic pop_check(input string tag, input logic [GW-1:0] e_idx, input logic [DW-1:0] e_data);
    if (res_idx_q.size() > 0) begin
      check({tag, "_idx"}, 64'(res_idx_q.pop_front()), 64'(e_idx));
      check({tag, "_data"}, 64'(res_data_q.pop_front()), 64'(e_data));
      void'(res_cyc_q.pop_front());
    end
  endtask

  task automatic check_model(input string tag);
    while (exp_idx_q.size() > 0 && res_idx_q.size() > 0) begin
      pop_check(tag, exp_idx_q.pop_front(), exp_data_q.pop_front());
    end
  endtask

  task automatic clear_all();
    cur_beats.delete();
    exp_idx_q.delete();
    exp_data_q.delete();
    res_idx_q.delete();
    res_data_q.delete();
    res_cyc_q.delete();
  endtask

  localparam logic [31:0] F_0P25 = 32'h3E800000;
  localparam logic [31:0] F_0P5  = 32'h3F000000;
  localparam logic [31:0] F_1    = 32'h3F800000;
  localparam logic [31:0] F_2    = 32'h40000000;
  localparam logic [31:0] F_3    = 32'h40400000;
  localparam logic [31:0] F_4    = 32'h40800000;
  localparam logic [31:0] F_5    = 32'h40A00000;
  localparam logic [31:0] F_M1   = 32'hBF800000;
  localparam logic [31:0] F_Z    = 32'h00000000;
  localparam logic [31:0] F_MZ   = 32'h80000000;

  initial begin
    logic [31:0] pool [6];
    int          nb;
    int          c0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", 64'(in_ready), 64'd1);

    // 1: single beat, latency
    send_beat(pack4(F_3, F_1, F_2, F_5), 1'b1);
    c0 = last_acc_cyc;
    wait_results("t1_count", 1);
    if (res_cyc_q.size() > 0) check("t1_latency", 64'(res_cyc_q[0] - c0), 64'(LAT));
    pop_check("t1", 16'd1, F_1);
    clear_all();

    // 2: three beats, min at beat2 lane3
    send_beat(pack4(F_1, F_2, F_3, F_4), 1'b0);
    send_beat(pack4(F_5, F_1, F_4, F_2), 1'b0);
    send_beat(pack4(F_3, F_2, F_1, F_0P25), 1'b1);
    wait_results("t2_count", 1);
    pop_check("t2", 16'd11, F_0P25);
    repeat (4) @(posedge clk);
    #1;
    check("t2_single_result", 64'(res_idx_q.size()), 64'd0);
    check("t2_idle_busy", 64'(busy), 64'd0);
    clear_all();

    // 3: tie across beats keeps earlier
    send_beat(pack4(F_1, F_2, F_0P5, F_3), 1'b0);
    send_beat(pack4(F_0P5, F_1, F_2, F_3), 1'b1);
    wait_results("t3_count", 1);
    pop_check("t3", 16'd2, F_0P5);
    clear_all();

    // 4: signs and signed zeros
    send_beat(pack4(F_0P5, F_M1, F_Z, F_MZ), 1'b1);
    wait_results("t4_count", 1);
    pop_check("t4", 16'd1, F_M1);
    send_beat(pack4(F_MZ, F_Z, F_1, F_2), 1'b1);
    wait_results("t4z_count", 1);
    pop_check("t4z", 16'd0, F_MZ);
    clear_all();

    // 5: stall with two back-to-back queries
    out_ready = 1'b0;
    send_beat(pack4(F_2, F_1, F_3, F_4), 1'b1);
    send_beat(pack4(F_4, F_3, F_0P5, F_1), 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_in_ready", 64'(in_ready), 64'd0);
      check("t5_stall_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_results("t5_count", 2);
    if (res_cyc_q.size() >= 2) check("t5_gap", 64'(res_cyc_q[1] - res_cyc_q[0]), 64'd1);
    pop_check("t5a", 16'd1, F_1);
    pop_check("t5b", 16'd2, F_0P5);
    clear_all();

    // 5b: ready held high, one result per query with no bubble
    for (int q = 0; q < 4; q++) send_beat(pack4(rand_float(), rand_float(), rand_float(), rand_float()), 1'b1);
    wait_results("t5c_count", 4);
    for (int i = 1; i < 4 && i < res_cyc_q.size(); i++)
      check("t5c_gap", 64'(res_cyc_q[i] - res_cyc_q[i-1]), 64'd1);
    check_model("t5c");
    clear_all();

    // Randomized queries with random backpressure
    rand_bp = 1'b1;
    for (int q = 0; q < 12; q++) begin
      for (int p = 0; p < 6; p++) pool[p] = rand_float();
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++)
        send_beat(pack4(pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                        pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)]), 1'(b == nb - 1));
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    wait_results("rnd_count", 12);
    check_model("rnd");
    clear_all();

    // 6: reset mid-query, then fresh query restarts batch numbering
    send_beat(pack4(F_1, F_2, F_3, F_4), 1'b0);
    send_beat(pack4(F_2, F_0P25, F_3, F_4), 1'b0);
    #1;
    check("t6_busy_mid", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    clear_all();
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_beat(pack4(F_3, F_4, F_2, F_5), 1'b0);
    send_beat(pack4(F_2, F_0P5, F_3, F_4), 1'b1);
    wait_results("t6_count", 1);
    pop_check("t6", 16'd5, F_0P5);
    check("t6_no_ovf", 64'(ovf), 64'd0);
    clear_all();

    // Batch counter wrap within one query
    for (int b = 0; b <= (1 << (GW - IW)); b++) begin
      if (b == 3) send_beat(pack4(F_1, F_2, F_0P25, F_1), 1'b0);
      else if (b == (1 << (GW - IW))) send_beat(pack4(F_1, F_0P25, F_1, F_1), 1'b1);
      else send_beat(pack4(F_1, F_2, F_1, F_3), 1'b0);
    end
    wait_results("ovf_count", 1);
    check("ovf_set", 64'(ovf), 64'd1);
    check_model("ovf");
    rst = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 64'(ovf), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
